kbd_cmd_scheduler: RTL and testbench

- Sits between ps2_kbd_adapter and game logic; replaces the per-key toggle/sync scheme.
- Decodes PS/2 make codes into a 4-bit command and queues them in a small FIFO.
- Issues commands one at a time over a valid/ready handshake, with enforced minimum spacing between issues.
- Owns the title/run/game-over input mode; drives show_title.

---
 rtl/kbd_cmd_scheduler_if.sv | 21 ++
 rtl/kbd_cmd_scheduler.sv | 165 ++++++++++++++++
 tb/tb_kbd_cmd_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_cmd_scheduler_if.sv
// Command handshake between the keyboard scheduler and the game logic.
// The scheduler is the master: it presents cmd_valid/cmd_code and the game
// logic answers with cmd_ready.
`timescale 1ns/1ps
interface kbd_cmd_scheduler_if;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_code,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        output cmd_ready
    );
endinterface

// File: rtl/kbd_cmd_scheduler.sv
// Keyboard command scheduler: decodes PS/2 make codes into 4-bit game commands,
// queues them, and issues them one at a time with a minimum spacing between
// issues. Also owns the title/run/game-over input mode.
//
// Spacing: the gap counter is reloaded with GAP_CYCLES-1 on every completed
// handshake and a new command may be loaded on the edge where the counter
// reaches (or sits at) zero. cmd_valid therefore rises at most once every
// GAP_CYCLES cycles, and GAP_CYCLES=1 gives back-to-back issue.
`timescale 1ns/1ps
module kbd_cmd_scheduler #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [7:0]                   scan_code,
    input  logic                         make_pulse,
    input  logic                         game_over,
    kbd_cmd_scheduler_if.master          cmd,
    output logic                         show_title,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {TITLE, RUN, OVER} state_t;

    state_t          state_q, state_d;
    logic [3:0]      mem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [GW-1:0]   gapCnt_q, gapCnt_d;
    logic            cmdValid_q, cmdValid_d;
    logic [3:0]      cmdCode_q, cmdCode_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      dropCnt_q, dropCnt_d;

    logic [3:0]      keyCode;
    logic            keyHit;
    logic            flush, handshake, load, push, dropFull, dropEvent;
    logic            fifoEmpty, fifoFull;

    function automatic logic [3:0] decodeKey(input logic [7:0] code);
        case (code)
            8'h6B, 8'h1C: decodeKey = 4'd1;
            8'h74, 8'h23: decodeKey = 4'd2;
            8'h75, 8'h1D: decodeKey = 4'd3;
            8'h72, 8'h1B: decodeKey = 4'd4;
            8'h29:        decodeKey = 4'd5;
            8'h2D:        decodeKey = 4'd6;
            8'h16:        decodeKey = 4'd7;
            8'h1E:        decodeKey = 4'd8;
            8'h26:        decodeKey = 4'd9;
            default:      decodeKey = 4'd0;
        endcase
    endfunction

    assign keyCode   = decodeKey(scan_code);
    assign keyHit    = make_pulse && (keyCode != 4'd0);
    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == FULL_COUNT);

    // Mode register; reset lands on the title screen.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= TITLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode transitions: any recognised key leaves the title, game_over toggles RUN/OVER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TITLE:   if (keyHit)     state_d = RUN;
            RUN:     if (game_over)  state_d = OVER;
            OVER:    if (!game_over) state_d = RUN;
            default:                 state_d = TITLE;
        endcase
    end

    // Queue, gap and output-stage next state; the RUN->OVER edge flushes everything in flight.
    always_comb begin
        flush      = (state_q == RUN) && game_over;
        handshake  = cmdValid_q && cmd.cmd_ready && !flush;
        gapCnt_d   = gapCnt_q;
        if (handshake) begin
            gapCnt_d = GAP_RELOAD;
        end else if (gapCnt_q != '0) begin
            gapCnt_d = gapCnt_q - GW'(1);
        end
        load       = (!cmdValid_q || cmd.cmd_ready) && (gapCnt_d == '0) && !fifoEmpty
                     && (state_q == RUN) && !flush;
        push       = keyHit && (state_q == RUN) && !flush && (!fifoFull || load);
        dropFull   = keyHit && (state_q == RUN) && !flush && fifoFull && !load;
        dropEvent  = dropFull || (keyHit && ((state_q == OVER) || flush));

        wrPtr_d    = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d    = load ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d    = count_q + CW'(push) - CW'(load);
        cmdValid_d = cmdValid_q;
        cmdCode_d  = cmdCode_q;
        if (flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            cmdValid_d = 1'b0;
            cmdCode_d  = 4'd0;
        end else if (load) begin
            cmdValid_d = 1'b1;
            cmdCode_d  = mem_q[rdPtr_q];
        end else if (handshake) begin
            cmdValid_d = 1'b0;
            cmdCode_d  = 4'd0;
        end

        overflow_d = overflow_q || dropFull;
        dropCnt_d  = (dropEvent && (dropCnt_q != 8'hFF)) ? dropCnt_q + 8'd1 : dropCnt_q;
    end

    // Control registers, all cleared immediately by the asynchronous reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            gapCnt_q   <= '0;
            cmdValid_q <= 1'b0;
            cmdCode_q  <= 4'd0;
            overflow_q <= 1'b0;
            dropCnt_q  <= 8'd0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            gapCnt_q   <= gapCnt_d;
            cmdValid_q <= cmdValid_d;
            cmdCode_q  <= cmdCode_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // Queue storage needs no reset; the count decides which entries are live.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wrPtr_q] <= keyCode;
        end
    end

    assign cmd.cmd_valid = cmdValid_q;
    assign cmd.cmd_code  = cmdCode_q;
    assign show_title    = (state_q == TITLE);
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign drop_cnt      = dropCnt_q;

endmodule

// File: tb/tb_kbd_cmd_scheduler.sv
// Self-checking bench for kbd_cmd_scheduler: a decode vector table plus
// hand-written sequences for spacing, overflow, flush and reset, with a
// scoreboard queue of expected issued commands.
`timescale 1ns/1ps
module tb_kbd_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int GAP   = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       make_pulse;
    logic       game_over;
    logic       show_title;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_cnt;

    kbd_cmd_scheduler_if cmdBus();

    kbd_cmd_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .scan_code  (scan_code),
        .make_pulse (make_pulse),
        .game_over  (game_over),
        .cmd        (cmdBus),
        .show_title (show_title),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    // 50 MHz clock.
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [7:0] scan;
        int         expCode;
    } vec_t;

    vec_t vecs[16];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   sb[$];
    int   riseT[$];
    bit   prevValid = 1'b0;
    int   lastCode = -1;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Called just before an edge: a handshake about to complete must match the scoreboard head.
    task automatic checkOutput();
        int exp;
        if (cmdBus.cmd_valid && cmdBus.cmd_ready) begin
            if (sb.size() == 0) begin
                check("unexpectedIssue", int'(cmdBus.cmd_code), -1);
            end else begin
                exp = sb.pop_front();
                check("issueOrder", int'(cmdBus.cmd_code), exp);
            end
            lastCode = int'(cmdBus.cmd_code);
        end
    endtask

    task automatic tick();
        checkOutput();
        @(posedge CLOCK_50);
        #1;
        cycle++;
        if (cmdBus.cmd_valid && !prevValid) riseT.push_back(cycle);
        prevValid = cmdBus.cmd_valid;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic [7:0] code, input int expPush);
        scan_code  = code;
        make_pulse = 1'b1;
        if (expPush > 0) sb.push_back(expPush);
        tick();
        make_pulse = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while (sb.size() > 0 && n < limit) begin
            tick();
            n++;
        end
        check("drainWithinBound", sb.size(), 0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500us;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        make_pulse = 1'b0;
        scan_code = 8'h00;
        game_over = 1'b0;
        cmdBus.cmd_ready = 1'b0;

        vecs[0]  = '{scan: 8'h6B, expCode: 1};
        vecs[1]  = '{scan: 8'h1C, expCode: 1};
        vecs[2]  = '{scan: 8'h74, expCode: 2};
        vecs[3]  = '{scan: 8'h23, expCode: 2};
        vecs[4]  = '{scan: 8'h75, expCode: 3};
        vecs[5]  = '{scan: 8'h1D, expCode: 3};
        vecs[6]  = '{scan: 8'h72, expCode: 4};
        vecs[7]  = '{scan: 8'h1B, expCode: 4};
        vecs[8]  = '{scan: 8'h29, expCode: 5};
        vecs[9]  = '{scan: 8'h2D, expCode: 6};
        vecs[10] = '{scan: 8'h16, expCode: 7};
        vecs[11] = '{scan: 8'h1E, expCode: 8};
        vecs[12] = '{scan: 8'h26, expCode: 9};
        vecs[13] = '{scan: 8'h5A, expCode: 0};
        vecs[14] = '{scan: 8'hF0, expCode: 0};
        vecs[15] = '{scan: 8'h6C, expCode: 0};

        #25;
        check("rstShowTitle", int'(show_title), 1);
        check("rstValid", int'(cmdBus.cmd_valid), 0);
        check("rstCode", int'(cmdBus.cmd_code), 0);
        check("rstFifoCount", int'(fifo_count), 0);
        check("rstOverflow", int'(overflow), 0);
        check("rstDropCnt", int'(drop_cnt), 0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        idle(2);

        // Title screen: unknown code ignored, recognised code starts the game without queuing.
        applyStimulus(8'h5A, 0);
        check("titleIgnoresUnknown", int'(show_title), 1);
        applyStimulus(8'h6B, 0);
        check("titleLeft", int'(show_title), 0);
        check("titleNotQueued", int'(fifo_count), 0);
        idle(2);
        check("titleNoIssue", int'(cmdBus.cmd_valid), 0);

        // Decode table with single-make latency checks.
        cmdBus.cmd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].scan, vecs[i].expCode);
            check("latFifoCount", int'(fifo_count), (vecs[i].expCode != 0) ? 1 : 0);
            check("latValidEarly", int'(cmdBus.cmd_valid), 0);
            tick();
            check("latValid", int'(cmdBus.cmd_valid), (vecs[i].expCode != 0) ? 1 : 0);
            check("decodeCode", int'(cmdBus.cmd_code), vecs[i].expCode);
            idle(20);
        end
        check("tableDrained", sb.size(), 0);

        // Three consecutive makes: ordered issue with cmd_valid rising every GAP cycles.
        riseT.delete();
        applyStimulus(8'h74, 2);
        applyStimulus(8'h75, 3);
        applyStimulus(8'h72, 4);
        waitDrain(100);
        check("riseCount", riseT.size(), 3);
        if (riseT.size() >= 3) begin
            check("riseSpacing1", riseT[1] - riseT[0], GAP);
            check("riseSpacing2", riseT[2] - riseT[1], GAP);
        end

        // Consumer stalled: six makes fill output register and queue, last one dropped.
        idle(20);
        cmdBus.cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'h29, (i < 5) ? 5 : 0);
            if (i >= 1) check("stallHoldCode", int'(cmdBus.cmd_code), 5);
        end
        check("fullFifoCount", int'(fifo_count), DEPTH);
        check("fullOverflow", int'(overflow), 1);
        check("fullDropCnt", int'(drop_cnt), 1);
        idle(3);
        check("stallStillValid", int'(cmdBus.cmd_valid), 1);
        check("stallStillCode", int'(cmdBus.cmd_code), 5);

        // Full queue: push lands on the same edge as the next load, so it is accepted.
        cmdBus.cmd_ready = 1'b1;
        tick();
        cmdBus.cmd_ready = 1'b0;
        check("acceptDropsValid", int'(cmdBus.cmd_valid), 0);
        idle(GAP - 2);
        check("gapStillIdle", int'(cmdBus.cmd_valid), 0);
        applyStimulus(8'h2D, 6);
        check("pushPopFifoCount", int'(fifo_count), DEPTH);
        check("pushPopValid", int'(cmdBus.cmd_valid), 1);
        check("pushPopOverflow", int'(overflow), 1);
        check("pushPopDropCnt", int'(drop_cnt), 1);
        cmdBus.cmd_ready = 1'b1;
        waitDrain(200);
        check("lastIssuedRot", lastCode, 6);

        // Game over flushes queue and output stage; makes are dropped until the game resumes.
        cmdBus.cmd_ready = 1'b0;
        idle(20);
        applyStimulus(8'h1C, 1);
        applyStimulus(8'h74, 2);
        applyStimulus(8'h23, 2);
        applyStimulus(8'h75, 3);
        check("preOverFifo", int'(fifo_count), 3);
        check("preOverValid", int'(cmdBus.cmd_valid), 1);
        game_over = 1'b1;
        tick();
        sb.delete();
        check("overFifoFlushed", int'(fifo_count), 0);
        check("overValidCleared", int'(cmdBus.cmd_valid), 0);
        check("overCodeCleared", int'(cmdBus.cmd_code), 0);
        check("overShowTitle", int'(show_title), 0);
        applyStimulus(8'h16, 0);
        check("overDropCnt", int'(drop_cnt), 2);
        check("overOverflowKept", int'(overflow), 1);
        check("overNoQueue", int'(fifo_count), 0);
        repeat (254) applyStimulus(8'h16, 0);
        check("dropCntSaturates", int'(drop_cnt), 255);
        game_over = 1'b0;
        tick();
        applyStimulus(8'h1E, 8);
        cmdBus.cmd_ready = 1'b1;
        waitDrain(50);
        check("resumeIssue", lastCode, 8);

        // Asynchronous reset in the middle of a stalled handshake.
        cmdBus.cmd_ready = 1'b0;
        idle(20);
        applyStimulus(8'h29, 5);
        applyStimulus(8'h2D, 6);
        applyStimulus(8'h16, 7);
        check("preRstValid", int'(cmdBus.cmd_valid), 1);
        check("preRstFifo", int'(fifo_count), 2);
        #5;
        reset = 1'b1;
        #1;
        sb.delete();
        check("asyncRstValid", int'(cmdBus.cmd_valid), 0);
        check("asyncRstCode", int'(cmdBus.cmd_code), 0);
        check("asyncRstFifo", int'(fifo_count), 0);
        check("asyncRstShowTitle", int'(show_title), 1);
        check("asyncRstOverflow", int'(overflow), 0);
        check("asyncRstDropCnt", int'(drop_cnt), 0);
        #20;
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
